instr_mem_read_arbiter: RTL and testbench
=========================================

// Module: instr_mem_read_arbiter
// PURPOSE
// - Sits directly downstream of the i-cache and the stream buffer, feeding both with line data.
// - Arbitrates i-cache demand misses (dem) and stream-buffer prefetches (pf) onto one AXI read port.
// - Issues one line burst per grant, with one transaction outstanding.
// - Routes returned beats to the owning requester; supports prefetch flush without breaking AXI.
// PARAMETERS
// ADDR_WIDTH          32  byte address width
// DATA_WIDTH          32  beat/word width
// BLOCK_OFFSET_WIDTH  2   log2(words per line); LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH
// STARVE_LIMIT        4   consecutive dem grants while pf waits before pf is forced; >=1
// ID_WIDTH            4   ARID/RID width; dem=0, pf=1
// PORTS
// clk           in   1                    clock
// rst           in   1                    synchronous reset, active-high
// dem_req_valid in   1                    i-cache miss request
// dem_req_ready out  1                    dem request accepted this cycle
// dem_req_addr  in   ADDR_WIDTH           miss address (any byte in line)
// dem_rvalid    out  1                    dem beat valid
// dem_rdata     out  DATA_WIDTH           dem beat data
// dem_rlast     out  1                    final dem beat
// pf_req_valid  in   1                    stream-buffer prefetch request
// pf_req_ready  out  1                    pf request accepted this cycle
// pf_req_addr   in   ADDR_WIDTH           prefetch line address
// pf_flush      in   1                    discard any pending/in-flight pf data
// pf_rvalid     out  1                    pf beat valid
// pf_rdata      out  DATA_WIDTH           pf beat data
// pf_rlast      out  1                    final pf beat
// m_arvalid     out  1                    AXI AR valid
// m_arready     in   1                    AXI AR ready
// m_araddr      out  ADDR_WIDTH           line-aligned address
// m_arlen       out  8                    always LINE_SIZE-1
// m_arid        out  ID_WIDTH             owner id
// m_rvalid      in   1                    AXI R valid
// m_rready      out  1                    AXI R ready
// m_rdata       in   DATA_WIDTH           AXI R data
// m_rlast       in   1                    AXI R last
// m_rid         in   ID_WIDTH             AXI R id
// err           out  1                    sticky protocol error
// BEHAVIOUR
// - Reset
//   - State is IDLE; owner, beat count, starve count and discard are cleared.
//   - All valid/ready outputs are 0; err is 0.
//   - Reset mid-burst abandons the transaction; the AXI slave shares this reset.
// - FSM IDLE -> ADDR -> DATA -> IDLE.
// - IDLE: grant and the matching *_req_ready are combinational in the same cycle.
//   - dem has priority over pf.
//   - pf wins if starve_cnt == STARVE_LIMIT.
//   - starve_cnt increments when dem is granted while pf_req_valid is high.
//   - starve_cnt clears on any pf grant or when pf_req_valid is low.
//   - Requests are latched into owner/araddr on grant; next state is ADDR.
// - ADDR: m_arvalid=1.
//   - m_araddr = {addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH+2], 0}.
//   - m_arlen = LINE_SIZE-1; m_arid = owner. Fields are stable until m_arready.
//   - Handshake -> DATA with beat_cnt=0.
// - DATA: m_rready=1. On each R handshake, the beat is registered to the owner's outputs.
//   - Owner outputs are valid for 1 cycle, 1 cycle after the handshake.
//   - Requesters have no backpressure.
//   - *_rlast = (beat_cnt == LINE_SIZE-1).
//   - After the final beat -> IDLE. The next grant is possible that same IDLE cycle.
// - err is set and sticky until reset on:
//   - m_rid != owner id;
//   - m_rlast disagreeing with the beat count.
//   - Counting continues by beat_cnt.
// - pf_flush
//   - In IDLE: blocks a pf grant that cycle; dem is unaffected.
//   - In ADDR/DATA with owner=pf: set discard. The AR completes and the remaining beats are drained.
//   - While discard is set, pf_rvalid is suppressed. discard clears on return to IDLE.
//   - With owner=dem: no effect.
// - Both valid with starve_cnt < STARVE_LIMIT: dem is granted; pf_req_ready stays 0.
// STRUCTURE
// - Shared package mem_arb_pkg:
//   - arb_state_t enum {IDLE, ADDR, DATA};
//   - owner_t enum {OWN_DEM, OWN_PF};
//   - ID constants DEM_ID=0, PF_ID=1.
// - Sub-module mem_arb_grant holds the priority + starvation counter logic.
// - FSM, beat counter and response routing stay in this module.
// TESTING
// - Single dem to 0x104, AXI ready:
//   - araddr=0x100, arlen=3, arid=0;
//   - 4 dem_rvalid pulses each 1 cycle after the R handshake; rlast on the 4th; pf outputs silent.
// - dem and pf both held valid, STARVE_LIMIT=4: grant order dem,dem,dem,dem,pf,dem...
// - pf burst to 0x200 with pf_flush in ADDR: AR still issued; 4 beats drained; pf_rvalid never asserts; next IDLE accepts dem.
// - R beat with m_rid=1 during a dem burst: err rises and stays 1; burst completes after 4 beats.
// - m_arready held low 10 cycles: m_arvalid/araddr stable throughout; no req_ready asserted.
// - rst asserted on the 2nd beat of a burst: next cycle, all outputs 0 and state IDLE; a new dem request is accepted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction-memory read arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    typedef enum logic {
        OWN_DEM,
        OWN_PF
    } owner_t;

    // AXI transaction ids identifying the requester that owns a burst.
    localparam int DEM_ID = 0;
    localparam int PF_ID  = 1;

endpackage

// File: rtl/mem_arb_grant.sv
// Demand/prefetch grant selection with a starvation counter protecting prefetch.
// Latency: grants are combinational; starve count updates on the clock edge.
// Backpressure: grants only while in_idle; prefetch is blocked during pf_flush.
// Ports: clk/rst; in_idle (arbiter can accept); dem_valid/pf_valid/pf_flush in;
//        grant_dem/grant_pf out (at most one set).
module mem_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_idle,
    input  logic dem_valid,
    input  logic pf_valid,
    input  logic pf_flush,
    output logic grant_dem,
    output logic grant_pf
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             at_limit;
    logic             pf_ok;

    assign at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    // Grants are gated by rst so no ready is ever seen during reset.
    assign pf_ok     = in_idle && !rst && pf_valid && !pf_flush;
    assign grant_pf  = pf_ok && (!dem_valid || at_limit);
    assign grant_dem = in_idle && !rst && dem_valid && !grant_pf;

    // Counts dem wins while pf waits; saturates so pf stays forced until it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!pf_valid || grant_pf) begin
            starve_cnt <= '0;
        end else if (grant_dem && !at_limit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/instr_mem_read_arbiter.sv
// Arbitrates i-cache demand misses and stream-buffer prefetches onto one AXI read port.
// Latency: grant same cycle in IDLE, AR next cycle, each beat delivered 1 cycle after R handshake.
// Backpressure: req_ready held low while a burst is open; R beats are never stalled.
// Ports: dem_req_*/pf_req_* requests; dem_r*/pf_r* routed beats; pf_flush drops pf data;
//        m_ar*/m_r* AXI read master (single outstanding burst); err sticky protocol error.
module instr_mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int BLOCK_OFFSET_WIDTH = 2,
    parameter int STARVE_LIMIT       = 4,
    parameter int ID_WIDTH           = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dem_req_valid,
    output logic                  dem_req_ready,
    input  logic [ADDR_WIDTH-1:0] dem_req_addr,
    output logic                  dem_rvalid,
    output logic [DATA_WIDTH-1:0] dem_rdata,
    output logic                  dem_rlast,
    input  logic                  pf_req_valid,
    output logic                  pf_req_ready,
    input  logic [ADDR_WIDTH-1:0] pf_req_addr,
    input  logic                  pf_flush,
    output logic                  pf_rvalid,
    output logic [DATA_WIDTH-1:0] pf_rdata,
    output logic                  pf_rlast,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [ID_WIDTH-1:0]   m_arid,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rlast,
    input  logic [ID_WIDTH-1:0]   m_rid,
    output logic                  err
);

    localparam int LINE_SIZE  = 1 << BLOCK_OFFSET_WIDTH;
    localparam int OFFSET_LSB = BLOCK_OFFSET_WIDTH + 2;   // word offset + byte offset
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT = BLOCK_OFFSET_WIDTH'(LINE_SIZE - 1);

    arb_state_t                    state, state_nxt;
    owner_t                        owner;
    logic [ADDR_WIDTH-1:0]         araddr_q;
    logic [BLOCK_OFFSET_WIDTH-1:0] beat_cnt;
    logic                          discard;
    logic [DATA_WIDTH-1:0]         rdata_q;
    logic                          grant_dem, grant_pf;
    logic [ADDR_WIDTH-1:0]         req_addr, req_line;
    logic [ID_WIDTH-1:0]           owner_id;
    logic                          is_last;
    logic                          unused_offset;

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .in_idle   (state == IDLE),
        .dem_valid (dem_req_valid),
        .pf_valid  (pf_req_valid),
        .pf_flush  (pf_flush),
        .grant_dem (grant_dem),
        .grant_pf  (grant_pf)
    );

    assign dem_req_ready = grant_dem;
    assign pf_req_ready  = grant_pf;

    assign req_addr      = grant_pf ? pf_req_addr : dem_req_addr;
    assign req_line      = {req_addr[ADDR_WIDTH-1:OFFSET_LSB], {OFFSET_LSB{1'b0}}};
    assign unused_offset = ^req_addr[OFFSET_LSB-1:0];

    assign owner_id  = (owner == OWN_PF) ? ID_WIDTH'(PF_ID) : ID_WIDTH'(DEM_ID);
    assign is_last   = (beat_cnt == LAST_BEAT);
    assign m_araddr  = araddr_q;
    assign m_arlen   = 8'(LINE_SIZE - 1);
    assign m_arid    = owner_id;
    assign dem_rdata = rdata_q;
    assign pf_rdata  = rdata_q;

    always_comb begin
        state_nxt = state;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_dem || grant_pf) state_nxt = ADDR;
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nxt = DATA;
            end
            DATA: begin
                m_rready = 1'b1;
                // Burst end follows our own beat count, not m_rlast.
                if (m_rvalid && is_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_DEM;
            araddr_q   <= '0;
            beat_cnt   <= '0;
            discard    <= 1'b0;
            rdata_q    <= '0;
            err        <= 1'b0;
            dem_rvalid <= 1'b0;
            dem_rlast  <= 1'b0;
            pf_rvalid  <= 1'b0;
            pf_rlast   <= 1'b0;
        end else begin
            state      <= state_nxt;
            dem_rvalid <= 1'b0;
            dem_rlast  <= 1'b0;
            pf_rvalid  <= 1'b0;
            pf_rlast   <= 1'b0;
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (grant_pf || grant_dem) begin
                        owner    <= grant_pf ? OWN_PF : OWN_DEM;
                        araddr_q <= req_line;
                    end
                end
                ADDR: begin
                    if (pf_flush && owner == OWN_PF) discard <= 1'b1;
                    if (m_arready) beat_cnt <= '0;
                end
                DATA: begin
                    if (pf_flush && owner == OWN_PF) discard <= 1'b1;
                    if (m_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        rdata_q  <= m_rdata;
                        if (owner == OWN_DEM) begin
                            dem_rvalid <= 1'b1;
                            dem_rlast  <= is_last;
                        end else if (!discard && !pf_flush) begin
                            // A flush arriving with this beat drops it as well.
                            pf_rvalid <= 1'b1;
                            pf_rlast  <= is_last;
                        end
                        if (m_rid != owner_id || m_rlast != is_last) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_read_arbiter.sv
module tb_instr_mem_read_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BOW = 2;
    localparam int SL  = 4;
    localparam int IDW = 4;
    localparam int LS  = 1 << BOW;
    localparam logic [AW-1:0] LINE_MASK = ~AW'((1 << (BOW + 2)) - 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           dem_req_valid, dem_req_ready;
    logic [AW-1:0]  dem_req_addr;
    logic           dem_rvalid, dem_rlast;
    logic [DW-1:0]  dem_rdata;
    logic           pf_req_valid, pf_req_ready, pf_flush;
    logic [AW-1:0]  pf_req_addr;
    logic           pf_rvalid, pf_rlast;
    logic [DW-1:0]  pf_rdata;
    logic           m_arvalid, m_arready;
    logic [AW-1:0]  m_araddr;
    logic [7:0]     m_arlen;
    logic [IDW-1:0] m_arid, m_rid;
    logic           m_rvalid, m_rready, m_rlast;
    logic [DW-1:0]  m_rdata;
    logic           err;

    instr_mem_read_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_OFFSET_WIDTH(BOW),
        .STARVE_LIMIT(SL), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .dem_req_valid(dem_req_valid), .dem_req_ready(dem_req_ready), .dem_req_addr(dem_req_addr),
        .dem_rvalid(dem_rvalid), .dem_rdata(dem_rdata), .dem_rlast(dem_rlast),
        .pf_req_valid(pf_req_valid), .pf_req_ready(pf_req_ready), .pf_req_addr(pf_req_addr),
        .pf_flush(pf_flush), .pf_rvalid(pf_rvalid), .pf_rdata(pf_rdata), .pf_rlast(pf_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .m_rid(m_rid), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one open line transaction, its owner and progress,
    // plus what the requester outputs must show next cycle.
    bit            mo_open, mo_ar_done, mo_pf, mo_drop, mo_err;
    int            mo_beat, mo_starve;
    logic [AW-1:0] mo_line;
    bit            ex_dv, ex_pv, ex_last;
    logic [DW-1:0] ex_data;

    // Observations of the last sampled cycle, and running statistics.
    logic          ob_dem_rdy, ob_pf_rdy, ob_arvalid, ob_rready, ob_dv, ob_pv, ob_dl, ob_pl, ob_err;
    logic [AW-1:0] ob_araddr;
    logic [7:0]    ob_arlen;
    logic [IDW-1:0] ob_arid;
    int            st_dv, st_pv, st_dlast_at, st_hs, st_rdy, st_arv;
    int            grant_q[$];

    task automatic clr_stats();
        st_dv = 0; st_pv = 0; st_dlast_at = 0; st_hs = 0; st_rdy = 0; st_arv = 0;
        grant_q.delete();
    endtask

    // One clock: check at the falling edge, advance the model across the rising edge.
    task automatic cycle();
        bit g_pf, g_dem, was_open, was_ar, last;
        @(negedge clk);
        g_pf  = !rst && !mo_open && pf_req_valid && !pf_flush && (!dem_req_valid || mo_starve == SL);
        g_dem = !rst && !mo_open && dem_req_valid && !g_pf;

        ob_dem_rdy = dem_req_ready; ob_pf_rdy = pf_req_ready; ob_arvalid = m_arvalid;
        ob_araddr = m_araddr; ob_arlen = m_arlen; ob_arid = m_arid; ob_rready = m_rready;
        ob_dv = dem_rvalid; ob_pv = pf_rvalid; ob_dl = dem_rlast; ob_pl = pf_rlast; ob_err = err;
        if (dem_req_ready) grant_q.push_back(0);
        if (pf_req_ready)  grant_q.push_back(1);
        if (dem_rvalid) st_dv++;
        if (pf_rvalid)  st_pv++;
        if (dem_rvalid && dem_rlast) st_dlast_at = st_dv;
        if (m_rvalid && m_rready) st_hs++;
        if (dem_req_ready || pf_req_ready) st_rdy++;
        if (m_arvalid) st_arv++;

        check_eq("dem_req_ready", dem_req_ready, g_dem);
        check_eq("pf_req_ready", pf_req_ready, g_pf);
        check_eq("m_arvalid", m_arvalid, mo_open && !mo_ar_done);
        check_eq("m_rready", m_rready, mo_open && mo_ar_done);
        if (mo_open && !mo_ar_done) begin
            check_eq("m_araddr", m_araddr, mo_line);
            check_eq("m_arlen", m_arlen, LS - 1);
            check_eq("m_arid", m_arid, mo_pf ? 1 : 0);
        end
        check_eq("dem_rvalid", dem_rvalid, ex_dv);
        check_eq("pf_rvalid", pf_rvalid, ex_pv);
        if (ex_dv) begin
            check_eq("dem_rlast", dem_rlast, ex_last);
            check_eq("dem_rdata", dem_rdata, ex_data);
        end
        if (ex_pv) begin
            check_eq("pf_rlast", pf_rlast, ex_last);
            check_eq("pf_rdata", pf_rdata, ex_data);
        end
        check_eq("err", err, mo_err);

        if (rst) begin
            mo_open = 0; mo_ar_done = 0; mo_pf = 0; mo_drop = 0; mo_err = 0;
            mo_beat = 0; mo_starve = 0; ex_dv = 0; ex_pv = 0; ex_last = 0;
        end else begin
            was_open = mo_open;
            was_ar   = mo_ar_done;
            ex_dv = 0; ex_pv = 0; ex_last = 0;
            if (was_open && mo_pf && pf_flush) mo_drop = 1;
            if (was_open && was_ar && m_rvalid) begin
                last    = (mo_beat == LS - 1);
                ex_data = m_rdata;
                ex_last = last;
                if (!mo_pf) ex_dv = 1;
                else if (!mo_drop && !pf_flush) ex_pv = 1;
                if (m_rid != IDW'(mo_pf) || m_rlast != last) mo_err = 1;
                mo_beat++;
                if (last) mo_open = 0;
            end
            if (was_open && !was_ar && m_arready) begin
                mo_ar_done = 1;
                mo_beat = 0;
            end
            if (!was_open) begin
                mo_drop = 0;
                if (g_pf || g_dem) begin
                    mo_open = 1; mo_ar_done = 0; mo_pf = g_pf;
                    mo_line = (g_pf ? pf_req_addr : dem_req_addr) & LINE_MASK;
                end
            end
            if (!pf_req_valid || g_pf) mo_starve = 0;
            else if (g_dem && mo_starve < SL) mo_starve++;
        end
        @(posedge clk);
        #1;
    endtask

    // Well-behaved AXI slave: beats only after the address phase, correct id and last.
    task automatic drive_slave(input int ar_pct, input int r_pct);
        m_arready = ($urandom_range(99) < ar_pct);
        m_rvalid  = mo_open && mo_ar_done && ($urandom_range(99) < r_pct);
        m_rdata   = $urandom;
        m_rid     = IDW'(mo_pf);
        m_rlast   = (mo_beat == LS - 1);
    endtask

    task automatic slave_idle();
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rid = '0; m_rdata = '0;
    endtask

    task automatic run_until_idle(input string tag);
        int n = 0;
        while ((mo_open || m_arvalid || m_rready) && n < 60) begin
            drive_slave(100, 100);
            cycle();
            n++;
        end
        check_eq({tag, "_done"}, n < 60, 1);
        slave_idle();
    endtask

    int exp_order[6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        rst = 1; dem_req_valid = 0; dem_req_addr = '0; pf_req_valid = 0; pf_req_addr = '0;
        pf_flush = 0;
        slave_idle();
        cycle();
        cycle();
        check_eq("rst_arvalid", ob_arvalid, 0);
        check_eq("rst_err", ob_err, 0);
        rst = 0;
        cycle();

        // Single demand miss to 0x104.
        clr_stats();
        dem_req_valid = 1; dem_req_addr = 32'h104;
        cycle();
        check_eq("t2_grant", ob_dem_rdy, 1);
        dem_req_valid = 0; m_arready = 1;
        cycle();
        check_eq("t2_araddr", ob_araddr, 32'h100);
        check_eq("t2_arlen", ob_arlen, 3);
        check_eq("t2_arid", ob_arid, 0);
        run_until_idle("t2");
        cycle();
        check_eq("t2_dem_beats", st_dv, 4);
        check_eq("t2_pf_beats", st_pv, 0);
        check_eq("t2_rlast_pos", st_dlast_at, 4);

        // Both held valid: pf forced after STARVE_LIMIT demand grants.
        clr_stats();
        dem_req_valid = 1; pf_req_valid = 1;
        for (int n = 0; n < 300 && grant_q.size() < 6; n++) begin
            dem_req_addr = $urandom; pf_req_addr = $urandom;
            drive_slave(100, 100);
            cycle();
        end
        dem_req_valid = 0; pf_req_valid = 0;
        check_eq("t3_grant_cnt", grant_q.size(), 6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            check_eq($sformatf("t3_order%0d", i), grant_q[i], exp_order[i]);
        run_until_idle("t3");
        cycle();

        // Prefetch flushed during its address phase.
        clr_stats();
        pf_req_valid = 1; pf_req_addr = 32'h200;
        cycle();
        check_eq("t4_grant", ob_pf_rdy, 1);
        pf_req_valid = 0; pf_flush = 1; m_arready = 0;
        cycle();
        check_eq("t4_arvalid", ob_arvalid, 1);
        check_eq("t4_araddr", ob_araddr, 32'h200);
        pf_flush = 0;
        run_until_idle("t4");
        cycle();
        check_eq("t4_drained", st_hs, 4);
        check_eq("t4_pf_beats", st_pv, 0);
        dem_req_valid = 1; dem_req_addr = 32'h340;
        cycle();
        check_eq("t4_next_dem", ob_dem_rdy, 1);
        dem_req_valid = 0;
        run_until_idle("t4b");
        cycle();

        // Wrong RID on a demand burst.
        clr_stats();
        dem_req_valid = 1; dem_req_addr = $urandom;
        cycle();
        dem_req_valid = 0;
        for (int n = 0; n < 60 && (mo_open || m_arvalid || m_rready); n++) begin
            drive_slave(100, 100);
            if (m_rvalid && mo_beat == 1) m_rid = IDW'(1);
            cycle();
        end
        slave_idle();
        cycle();
        check_eq("t5_err", ob_err, 1);
        check_eq("t5_beats", st_dv, 4);
        cycle(); cycle(); cycle();
        check_eq("t5_err_sticky", ob_err, 1);
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        check_eq("t5_err_clr", ob_err, 0);

        // AR held off for 10 cycles with both requesters asking.
        clr_stats();
        dem_req_valid = 1; dem_req_addr = 32'hABCD_1237;
        cycle();
        pf_req_valid = 1; pf_req_addr = $urandom; m_arready = 0;
        st_rdy = 0; st_arv = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("t6_araddr", ob_araddr, 32'hABCD_1230);
        end
        check_eq("t6_no_ready", st_rdy, 0);
        check_eq("t6_arvalid", st_arv, 10);
        dem_req_valid = 0; pf_req_valid = 0;
        run_until_idle("t6");
        cycle();

        // Reset landing on the second beat.
        clr_stats();
        dem_req_valid = 1; dem_req_addr = $urandom;
        cycle();
        dem_req_valid = 0;
        drive_slave(100, 0);
        cycle();
        drive_slave(100, 100);
        cycle();
        drive_slave(100, 100);
        rst = 1;
        cycle();
        rst = 0;
        slave_idle();
        cycle();
        check_eq("t7_arvalid", ob_arvalid, 0);
        check_eq("t7_rready", ob_rready, 0);
        check_eq("t7_dem_rvalid", ob_dv, 0);
        check_eq("t7_pf_rvalid", ob_pv, 0);
        check_eq("t7_rlast", ob_dl | ob_pl, 0);
        check_eq("t7_ready", ob_dem_rdy | ob_pf_rdy, 0);
        check_eq("t7_err", ob_err, 0);
        dem_req_valid = 1; dem_req_addr = $urandom;
        cycle();
        check_eq("t7_new_dem", ob_dem_rdy, 1);
        dem_req_valid = 0;
        run_until_idle("t7");
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst           = ($urandom_range(299) == 0);
            dem_req_valid = $urandom_range(1);
            pf_req_valid  = $urandom_range(1);
            pf_flush      = ($urandom_range(9) == 0);
            dem_req_addr  = $urandom;
            pf_req_addr   = $urandom;
            drive_slave(70, 70);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
